// File: rtl/mux_8to1_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_8to1_if
//  Description : Bus bundle for the 8-way byte selector: the 3-bit select,
//                eight data inputs and the selected output.
//                  s      - select code, value k steers input ik to y
//                  i0..i7 - data inputs, WIDTH bits each
//                  y      - selected data, WIDTH bits
//                Modport master drives s and i0..i7 and observes y;
//                modport slave is the selector side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_8to1_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       s;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [WIDTH-1:0] i4;
    logic [WIDTH-1:0] i5;
    logic [WIDTH-1:0] i6;
    logic [WIDTH-1:0] i7;
    logic [WIDTH-1:0] y;

    modport master (
        output s, i0, i1, i2, i3, i4, i5, i6, i7,
        input  y
    );

    modport slave (
        input  s, i0, i1, i2, i3, i4, i5, i6, i7,
        output y
    );
endinterface
`default_nettype wire

// File: rtl/mux_8to1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_8to1
//  Description : Eight-way WIDTH-bit data selector with optional output
//                register. The byte chosen by bus.s is presented on bus.y.
//  Ports       : clk  - system clock, rising edge active
//                rst  - asynchronous active-high reset, clears y to zero
//                bus  - mux_8to1_if slave modport (s, i0..i7 in; y out)
//  Parameters  : WIDTH   - data width of each input and of y
//                REG_OUT - 1: y registered (one-cycle latency)
//                          0: y combinational, clk/rst unused
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_8to1 #(
    parameter int WIDTH   = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mux_8to1_if.slave   bus
);

    localparam int c_NUM_INPUTS = 8;

    // Gather the inputs into an array so selection is a single parallel
    // index: every code of s is valid, no priority chain, no latch.
    logic [WIDTH-1:0] w_bank [c_NUM_INPUTS];
    logic [WIDTH-1:0] w_sel;

    assign w_bank[0] = bus.i0;
    assign w_bank[1] = bus.i1;
    assign w_bank[2] = bus.i2;
    assign w_bank[3] = bus.i3;
    assign w_bank[4] = bus.i4;
    assign w_bank[5] = bus.i5;
    assign w_bank[6] = bus.i6;
    assign w_bank[7] = bus.i7;

    assign w_sel = w_bank[bus.s];

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] r_y;

            // Reset clears the output immediately; afterwards the register
            // reloads every cycle (there is deliberately no enable).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_y <= '0;
                end else begin
                    r_y <= w_sel;
                end
            end

            assign bus.y = r_y;
        end else begin : g_comb
            assign bus.y = w_sel;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mux_8to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_8to1
//  Description : Self-checking bench for mux_8to1. A registered instance and
//                a combinational instance share the same stimulus; a
//                behavioural model tracks the expected outputs every cycle,
//                and directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_8to1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] exp_y = 8'h00;
    logic [7:0] pat [8] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h3C, 8'hC3};

    always #5 clk = ~clk;

    mux_8to1_if #(.WIDTH(8)) bus ();
    mux_8to1_if #(.WIDTH(8)) bus_c ();

    // The combinational instance sees exactly the same select and data.
    assign bus_c.s  = bus.s;
    assign bus_c.i0 = bus.i0;
    assign bus_c.i1 = bus.i1;
    assign bus_c.i2 = bus.i2;
    assign bus_c.i3 = bus.i3;
    assign bus_c.i4 = bus.i4;
    assign bus_c.i5 = bus.i5;
    assign bus_c.i6 = bus.i6;
    assign bus_c.i7 = bus.i7;

    mux_8to1 #(.WIDTH(8), .REG_OUT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux_8to1 #(.WIDTH(8), .REG_OUT(1'b0)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic logic [7:0] pick();
        logic [7:0] a [8];
        a[0] = bus.i0; a[1] = bus.i1; a[2] = bus.i2; a[3] = bus.i3;
        a[4] = bus.i4; a[5] = bus.i5; a[6] = bus.i6; a[7] = bus.i7;
        return a[bus.s];
    endfunction

    // Registered output = value picked at the previous edge, zero in reset.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_y = 8'h00;
        else     exp_y = pick();
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_reg", bus.y, exp_y);
            check("model_comb", bus_c.y, pick());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input int k, input logic [7:0] v);
        case (k)
            0: bus.i0 = v;
            1: bus.i1 = v;
            2: bus.i2 = v;
            3: bus.i3 = v;
            4: bus.i4 = v;
            5: bus.i5 = v;
            6: bus.i6 = v;
            default: bus.i7 = v;
        endcase
    endtask

    initial begin
        bus.s = 3'd0;
        for (int k = 0; k < 8; k++) set_in(k, 8'h00);

        // Reset asserts with no clock edge in between.
        #1 rst = 1'b1;
        #1 check("reset_async", bus.y, 8'h00);
        tick();
        check("reset_hold", bus.y, 8'h00);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        check("reset_release", bus.y, 8'h00);

        // Select sweep with inputs equal to their index.
        for (int k = 0; k < 8; k++) set_in(k, 8'(k));
        for (int k = 0; k < 8; k++) begin
            bus.s = 3'(k);
            tick();
            check("sweep", bus.y, 8'(k));
            tick();
        end

        // Distinct bit patterns.
        for (int k = 0; k < 8; k++) set_in(k, pat[k]);
        for (int k = 0; k < 8; k++) begin
            bus.s = 3'(k);
            tick();
            check("pattern", bus.y, pat[k]);
            tick();
        end

        // Isolation: unselected inputs toggle, output must not move.
        bus.s = 3'd3;
        set_in(3, 8'h33);
        tick();
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 8; k++)
                if (k != 3) set_in(k, 8'($urandom));
            tick();
            check("isolation", bus.y, 8'h33);
        end

        // Simultaneous change of select and newly selected data.
        bus.s = 3'd2;
        set_in(2, 8'h22);
        set_in(6, 8'h00);
        tick();
        check("simul_before", bus.y, 8'h22);
        bus.s = 3'd6;
        set_in(6, 8'h66);
        #6 check("simul_no_early", bus.y, 8'h22);
        @(posedge clk);
        #2 check("simul_after", bus.y, 8'h66);

        // Mid-operation reset pulse between clock edges.
        bus.s = 3'd7;
        set_in(7, 8'h77);
        tick();
        tick();
        check("mid_settled", bus.y, 8'h77);
        rst = 1'b1;
        #1 check("mid_reset", bus.y, 8'h00);
        #1 rst = 1'b0;
        #1 check("mid_reset_held", bus.y, 8'h00);
        tick();
        check("mid_resume", bus.y, 8'h77);

        // Randomized traffic, checked by the per-cycle model compare.
        for (int c = 0; c < 300; c++) begin
            bus.s = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) set_in(k, 8'($urandom));
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
